aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative round sequencer for the AES-128 cipher datapath in aes_cipher_top.
- Accepts a block through a valid/ready handshake, then drives the load, round, final-round and output-capture strobes to the state register and key expander.
- Presents the result through a valid/ready output handshake, with back-to-back block acceptance.

Parameters:
- NR, 10, number of cipher rounds (legal range 2..15).
- CW, 4, round counter width; requires 2**CW > NR.
- BCW, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; returns the FSM to IDLE.
- in_valid  in  1  plaintext and key present on the datapath inputs.
- in_ready  out  1  controller can accept a block this cycle.
- out_valid  out  1  ciphertext register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- dp_load  out  1  load state = text ^ key.
- dp_round_en  out  1  state register performs one round.
- dp_final  out  1  current round skips MixColumns.
- key_load  out  1  key expander loads the cipher key.
- key_step  out  1  key expander advances one round key.
- rcon_idx  out  CW  Rcon index for the current key step.
- out_reg_en  out  1  capture the datapath result into the output register.
- busy  out  1  FSM not in IDLE.
- blk_cnt  out  BCW  completed blocks; wraps.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, cnt = 0, blk_cnt = 0.
  - All strobes = 0, out_valid = 0, busy = 0.
  - in_ready = 1 once reset is released.
- States: IDLE, ROUND, FINAL, HOLD.
- State is registered; all strobes are Moore-decoded except dp_load, key_load and in_ready, which are combinational.
- accept = in_valid & in_ready.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is forced to 0 when clr = 1.
- IDLE:
  - On accept: dp_load = key_load = 1 in the same cycle; next = ROUND, cnt <= 1.
  - Otherwise stay in IDLE.
- ROUND:
  - dp_round_en = key_step = 1, dp_final = 0, rcon_idx = cnt - 1.
  - cnt <= cnt + 1.
  - When cnt == NR-1, next = FINAL.
- FINAL:
  - dp_round_en = key_step = dp_final = out_reg_en = 1, rcon_idx = NR - 1.
  - next = HOLD; blk_cnt <= blk_cnt + 1 (wraps modulo 2**BCW).
- HOLD:
  - out_valid = 1.
  - out_ready = 0: stay in HOLD, output stable.
  - out_ready = 1 and accept: dp_load = key_load = 1, next = ROUND, cnt <= 1 (back-to-back block).
  - out_ready = 1 and no accept: next = IDLE.
- Latency:
  - Accept in cycle T gives out_valid high from T+NR+1.
  - NR=10: 11 cycles.
  - Back-to-back throughput is one block per NR+1 cycles.
- busy = (state != IDLE).
- clr:
  - Highest priority after rst. Next state = IDLE, cnt <= 0.
  - Strobes in the clr cycle stay Moore-decoded from the current state, except dp_load/key_load, which are 0 because in_ready = 0.
  - A block in flight is discarded; out_valid drops the cycle after.
  - blk_cnt is unchanged, including when clr coincides with FINAL.
- Invariants:
  - dp_load and dp_round_en never assert together.
  - key_step is never asserted in IDLE or HOLD.
  - out_reg_en asserts exactly once per completed block.
- Asynchronous reset mid-block: the block is lost; no strobe glitches after release.

Decomposition:
- Package aes_ctrl_pkg:
  - State enum: IDLE, ROUND, FINAL, HOLD (2-bit).
  - Constants AES128_NR = 10 and AES_RCON_W = 4.
- Single module.
- One natural sub-module, aes_ctrl_cnt: round counter with load-to-1, increment and terminal-count compare.

Test Plan:
- Reset, then a single block with out_ready = 1:
  - Accept at cycle 0 gives dp_load = key_load = 1 at cycle 0.
  - dp_round_en at cycles 1..10, with rcon_idx 0..9 across those cycles.
  - dp_final and out_reg_en only at cycle 10; out_valid at cycle 11; blk_cnt = 1.
- Output backpressure:
  - out_ready = 0 for 5 cycles after out_valid: out_valid stays high, in_ready = 0, no strobes.
  - Releasing out_ready returns the FSM to IDLE the next cycle.
- Back-to-back:
  - in_valid held high and out_ready = 1 gives accepts at cycles 0, 11 and 22.
  - dp_load asserts in the same cycles as out_valid & out_ready; blk_cnt = 3 after 33 cycles.
- clr abort:
  - clr at cycle 5 of a block: IDLE at cycle 6, out_valid never asserts, blk_cnt unchanged.
  - A new accept at cycle 6 completes normally.
- Asynchronous reset mid-round:
  - rst low at cycle 4 between clock edges: all outputs go to 0 immediately and blk_cnt = 0.
  - After release, in_ready = 1.
- Wrap:
  - Preload blk_cnt near the maximum via 65,535 fast blocks, or with NR = 2 and BCW = 4 run 16 blocks.
  - Required: blk_cnt wraps to 0.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES-128 round controller: FSM state encoding and the
// Moore strobe bundle decoded from state.
package aes_ctrl_pkg;

  localparam int AES128_NR  = 10;
  localparam int AES_RCON_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic round_en;
    logic final_rnd;
    logic key_step;
    logic out_reg_en;
    logic out_valid;
    logic busy;
  } strb_t;

  function automatic strb_t strb_decode(input state_e s);
    strb_t d;
    d            = '0;
    d.round_en   = (s == ROUND) || (s == FINAL);
    d.key_step   = (s == ROUND) || (s == FINAL);
    d.final_rnd  = (s == FINAL);
    d.out_reg_en = (s == FINAL);
    d.out_valid  = (s == HOLD);
    d.busy       = (s != IDLE);
    return d;
  endfunction

endpackage

// File: rtl/aes_ctrl_cnt.sv
// Round counter: synchronous clear, load-to-1 on block accept, increment per
// round, and terminal-count flag when the last full round is in progress.
module aes_ctrl_cnt
  import aes_ctrl_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int CW = AES_RCON_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output logic          tc
);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)       cnt_nxt = '0;
    else if (load) cnt_nxt = CW'(1);
    else if (inc)  cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  assign tc = (cnt == CW'(NR - 1));

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: accepts a block, walks NR rounds, then holds
// the result until the consumer takes it, overlapping the next accept.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR  = AES128_NR,
  parameter int CW  = AES_RCON_W,
  parameter int BCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           dp_load,
  output logic           dp_round_en,
  output logic           dp_final,
  output logic           key_load,
  output logic           key_step,
  output logic [CW-1:0]  rcon_idx,
  output logic           out_reg_en,
  output logic           busy,
  output logic [BCW-1:0] blk_cnt
);

  if (NR < 2 || NR > 15 || (2 ** CW) <= NR) begin : g_bad_param
    $error("aes_round_ctrl: NR must be 2..15 and fit in CW bits");
  end

  state_e        state, nxt;
  strb_t         strb;
  logic          accept;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tc;

  // in_ready is held low while reset is asserted so nothing is accepted then.
  assign in_ready = rst & ~clr & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;
  assign dp_load  = accept;
  assign key_load = accept;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = ROUND;
      ROUND:   if (tc)     nxt = FINAL;
      FINAL:               nxt = HOLD;
      HOLD:    if (out_ready) nxt = accept ? ROUND : IDLE;
      default:             nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  aes_ctrl_cnt #(.NR(NR), .CW(CW)) u_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (clr),
    .load    (accept),
    .inc     (state == ROUND),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .tc      (tc)
  );

  // Strobes are registered from the next state so they stay pure Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      strb     <= '0;
      rcon_idx <= '0;
      blk_cnt  <= '0;
    end else begin
      state <= nxt;
      strb  <= strb_decode(nxt);
      if (nxt == FINAL)      rcon_idx <= CW'(NR - 1);
      else if (nxt == ROUND) rcon_idx <= cnt_nxt - CW'(1);
      else                   rcon_idx <= '0;
      if (state == FINAL && !clr) blk_cnt <= blk_cnt + BCW'(1);
    end
  end

  assign dp_round_en = strb.round_en;
  assign dp_final    = strb.final_rnd;
  assign key_step    = strb.key_step;
  assign out_reg_en  = strb.out_reg_en;
  assign out_valid   = strb.out_valid;
  assign busy        = strb.busy;

  a_load_vs_round: assert property (@(posedge clk) disable iff (!rst)
    !(dp_load && dp_round_en));
  a_no_step_idle: assert property (@(posedge clk) disable iff (!rst)
    ((state == IDLE) || (state == HOLD)) |-> !key_step);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default NR=10 instance plus an NR=2,
// BCW=4 instance for the block counter wrap.
module tb_aes_round_ctrl;

  logic clk, rst;
  logic clr, in_valid, out_ready;
  logic in_ready, out_valid, dp_load, dp_round_en, dp_final, key_load, key_step;
  logic out_reg_en, busy;
  logic [3:0]  rcon_idx;
  logic [15:0] blk_cnt;

  logic clr_w, in_valid_w, out_ready_w;
  logic in_ready_w, out_valid_w, dp_load_w, dp_round_en_w, dp_final_w, key_load_w;
  logic key_step_w, out_reg_en_w, busy_w;
  logic [1:0] rcon_idx_w;
  logic [3:0] blk_cnt_w;

  int n_chk = 0;
  int n_err = 0;
  int exp_blk = 0;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .dp_load(dp_load),
    .dp_round_en(dp_round_en), .dp_final(dp_final), .key_load(key_load),
    .key_step(key_step), .rcon_idx(rcon_idx), .out_reg_en(out_reg_en),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  aes_round_ctrl #(.NR(2), .CW(2), .BCW(4)) dut_w (
    .clk(clk), .rst(rst), .clr(clr_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .dp_load(dp_load_w),
    .dp_round_en(dp_round_en_w), .dp_final(dp_final_w), .key_load(key_load_w),
    .key_step(key_step_w), .rcon_idx(rcon_idx_w), .out_reg_en(out_reg_en_w),
    .busy(busy_w), .blk_cnt(blk_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point, half a cycle away from the active edge.
  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clr_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;

    // reset state
    #12;
    chk("rst_in_ready",  32'(in_ready), 32'(0));
    chk("rst_busy",      32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_round_en",  32'(dp_round_en), 32'(0));
    chk("rst_blk_cnt",   32'(blk_cnt), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'(1));

    // single block, out_ready high
    cyc(); in_valid = 1'b1;
    smp();
    chk("blk_dp_load",  32'(dp_load), 32'(1));
    chk("blk_key_load", 32'(key_load), 32'(1));
    chk("blk_c0_round", 32'(dp_round_en), 32'(0));
    for (int c = 1; c <= 10; c++) begin
      cyc(); in_valid = 1'b0;
      smp();
      chk($sformatf("blk_round_c%0d", c), 32'(dp_round_en), 32'(1));
      chk($sformatf("blk_kstep_c%0d", c), 32'(key_step), 32'(1));
      chk($sformatf("blk_rcon_c%0d", c),  32'(rcon_idx), 32'(c - 1));
      chk($sformatf("blk_final_c%0d", c), 32'(dp_final), 32'(c == 10));
      chk($sformatf("blk_oreg_c%0d", c),  32'(out_reg_en), 32'(c == 10));
      chk($sformatf("blk_ov_c%0d", c),    32'(out_valid), 32'(0));
    end
    cyc(); smp();
    exp_blk = 1;
    chk("blk_out_valid", 32'(out_valid), 32'(1));
    chk("blk_cnt1",      32'(blk_cnt), 32'(exp_blk));
    chk("blk_hold_rdy",  32'(in_ready), 32'(1));
    cyc(); smp();
    chk("blk_idle", 32'(busy), 32'(0));

    // output backpressure
    cyc(); in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    repeat (9) cyc();
    out_ready = 1'b0;
    cyc();
    exp_blk++;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("bp_ov_%0d", k),    32'(out_valid), 32'(1));
      chk($sformatf("bp_rdy_%0d", k),   32'(in_ready), 32'(0));
      chk($sformatf("bp_round_%0d", k), 32'(dp_round_en), 32'(0));
      chk($sformatf("bp_oreg_%0d", k),  32'(out_reg_en), 32'(0));
      chk($sformatf("bp_blk_%0d", k),   32'(blk_cnt), 32'(exp_blk));
      cyc();
    end
    out_ready = 1'b1;
    smp();
    chk("bp_rel_ov", 32'(out_valid), 32'(1));
    cyc(); smp();
    chk("bp_idle_busy", 32'(busy), 32'(0));
    chk("bp_idle_ov",   32'(out_valid), 32'(0));

    // back-to-back with in_valid held
    cyc(); in_valid = 1'b1;
    smp();
    chk("b2b_load_c0", 32'(dp_load), 32'(1));
    for (int c = 1; c <= 32; c++) begin
      cyc(); smp();
      chk($sformatf("b2b_load_c%0d", c), 32'(dp_load), 32'(c % 11 == 0));
      chk($sformatf("b2b_ov_c%0d", c),   32'(out_valid), 32'(c % 11 == 0));
    end
    cyc(); in_valid = 1'b0;
    smp();
    exp_blk += 3;
    chk("b2b_blk_cnt", 32'(blk_cnt), 32'(exp_blk));
    cyc(); smp();
    chk("b2b_idle", 32'(busy), 32'(0));

    // clr mid-block, then a fresh block right after
    cyc(); in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    repeat (3) cyc();
    cyc(); clr = 1'b1;
    smp();
    chk("clr_in_ready", 32'(in_ready), 32'(0));
    chk("clr_round_en", 32'(dp_round_en), 32'(1));
    chk("clr_rcon",     32'(rcon_idx), 32'(4));
    cyc(); clr = 1'b0; in_valid = 1'b1;
    smp();
    chk("clr_idle_busy", 32'(busy), 32'(0));
    chk("clr_reload",    32'(dp_load), 32'(1));
    chk("clr_blk",       32'(blk_cnt), 32'(exp_blk));
    cyc(); in_valid = 1'b0;
    for (int k = 7; k <= 16; k++) begin
      smp();
      chk($sformatf("clr_ov_c%0d", k), 32'(out_valid), 32'(0));
      cyc();
    end
    smp();
    exp_blk++;
    chk("clr_new_ov",  32'(out_valid), 32'(1));
    chk("clr_new_blk", 32'(blk_cnt), 32'(exp_blk));
    cyc(); smp();

    // clr landing on the final round leaves blk_cnt untouched
    cyc(); in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    repeat (8) cyc();
    cyc(); clr = 1'b1;
    smp();
    chk("clrf_final", 32'(dp_final), 32'(1));
    chk("clrf_oreg",  32'(out_reg_en), 32'(1));
    cyc(); clr = 1'b0;
    smp();
    chk("clrf_ov",   32'(out_valid), 32'(0));
    chk("clrf_busy", 32'(busy), 32'(0));
    chk("clrf_blk",  32'(blk_cnt), 32'(exp_blk));

    // asynchronous reset mid-round
    cyc(); in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    repeat (3) cyc();
    chk("arst_pre_busy", 32'(busy), 32'(1));
    #2; rst = 1'b0; #1;
    chk("arst_round", 32'(dp_round_en), 32'(0));
    chk("arst_kstep", 32'(key_step), 32'(0));
    chk("arst_busy",  32'(busy), 32'(0));
    chk("arst_ov",    32'(out_valid), 32'(0));
    chk("arst_rdy",   32'(in_ready), 32'(0));
    chk("arst_rcon",  32'(rcon_idx), 32'(0));
    chk("arst_blk",   32'(blk_cnt), 32'(0));
    @(negedge clk); #2; rst = 1'b1;
    smp();
    chk("arst_rel_rdy",  32'(in_ready), 32'(1));
    chk("arst_rel_busy", 32'(busy), 32'(0));

    // NR=2, BCW=4: 16 back-to-back blocks wrap the counter to 0
    cyc(); in_valid_w = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      if (c > 0) cyc();
      if (c == 46) in_valid_w = 1'b0;
      smp();
      chk($sformatf("wrap_blk_c%0d", c),  32'(blk_cnt_w), 32'((c / 3) % 16));
      chk($sformatf("wrap_load_c%0d", c), 32'(dp_load_w), 32'((c % 3 == 0) && (c <= 45)));
      if (c == 3) chk("wrap_latency", 32'(out_valid_w), 32'(1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
